// File: rtl/sample_pwm_dac_pkg.sv
// Shared types and constants for the sample-driven PWM DAC.
// State encoding and counter widths live here so every unit agrees.
package pwm_dac_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int PSC_W          = 16;

endpackage

// File: rtl/sample_pwm_dac_if.sv
// Valid/ready sample stream from the waveform generator.
// The generator drives the master side, the DAC is the slave.
interface sample_pwm_dac_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/sample_pwm_dac_tick_gen.sv
// PWM tick prescaler: one tick every PRESCALE clocks while enabled.
// Held at zero when disabled so the first period starts phase-aligned.
module pwm_tick_gen
  import pwm_dac_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [PSC_W-1:0] LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc_q;
  logic [PSC_W-1:0] psc_d;

  assign tick = en && (psc_q == LAST);

  always_comb begin
    psc_d = psc_q;
    if (!en) begin
      psc_d = '0;
    end else if (tick) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/sample_pwm_dac.sv
// Sample-to-PWM converter: one sample per 2**DATA_W-tick period,
// with a one-entry hold buffer and boundary bypass.
module sample_pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  sample_pwm_dac_if.slave  smp_if,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);

  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              pwm_q, pwm_d;
  logic              ps_q, ps_d;
  logic              ur_q, ur_d;

  logic tick;
  logic xfer;
  logic boundary;

  assign smp_if.sample_ready = !hold_full_q;
  assign xfer     = smp_if.sample_valid && !hold_full_q;
  assign boundary = tick && (cnt_q == CNT_MAX);

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == RUN),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ps_d        = 1'b0;
    ur_d        = 1'b0;
    pwm_d       = (state_q == RUN) && (cnt_q < duty_q);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer) begin
          duty_d  = smp_if.sample_in;
          state_d = RUN;
          ps_d    = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          cnt_d = cnt_q + DATA_W'(1);
        end
        // Full hold forces ready low, so consume and accept never collide.
        if (boundary) begin
          ps_d = 1'b1;
          if (hold_full_q) begin
            duty_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            duty_d = smp_if.sample_in;
          end else begin
            ur_d = 1'b1;
          end
        end else if (xfer) begin
          hold_d      = smp_if.sample_in;
          hold_full_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      duty_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
      ur_q        <= ur_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_sample_pwm_dac.sv
// Directed bench for sample_pwm_dac: PRESCALE=1 instance A and
// PRESCALE=4 instance B sharing one clock.
module tb_sample_pwm_dac;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic pwm_a, ps_a, ur_a;
  logic pwm_b, ps_b, ur_b;

  int checks;
  int errors;
  int hi_a, psn_a, urn_a;
  int hi_b, psn_b, urn_b;

  sample_pwm_dac_if #(.DATA_W(8)) ifa ();
  sample_pwm_dac_if #(.DATA_W(8)) ifb ();

  sample_pwm_dac #(
    .DATA_W   (8),
    .PRESCALE (1)
  ) dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .smp_if       (ifa),
    .pwm_out      (pwm_a),
    .period_start (ps_a),
    .underrun     (ur_a)
  );

  sample_pwm_dac #(
    .DATA_W   (8),
    .PRESCALE (4)
  ) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .smp_if       (ifb),
    .pwm_out      (pwm_b),
    .period_start (ps_b),
    .underrun     (ur_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    hi_a = 0; psn_a = 0; urn_a = 0;
    hi_b = 0; psn_b = 0; urn_b = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pwm_a) hi_a++;
      if (ps_a)  psn_a++;
      if (ur_a)  urn_a++;
      if (pwm_b) hi_b++;
      if (ps_b)  psn_b++;
      if (ur_b)  urn_b++;
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    ifa.sample_in    = d;
    ifa.sample_valid = 1'b1;
    step(1);
    ifa.sample_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    ifb.sample_in    = d;
    ifb.sample_valid = 1'b1;
    step(1);
    ifb.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.sample_valid = 1'b0;
    ifa.sample_in    = '0;
    ifb.sample_valid = 1'b0;
    ifb.sample_in    = '0;
    #12;
    checks++;
    if ({pwm_a, ps_a, ur_a, ifa.sample_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_out: got %b want 0001",
               {pwm_a, ps_a, ur_a, ifa.sample_ready});
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(3);
    checks++;
    if (ps_a !== 1'b0 || pwm_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: ps=%b pwm=%b want 0 0", ps_a, pwm_a);
    end
  endtask

  task automatic test_single();
    send_a(8'd64);
    checks++;
    if (ps_a !== 1'b1) begin
      errors++;
      $display("FAIL first_ps: got %b want 1", ps_a);
    end
    clr();
    step(256);
    checks++;
    if (hi_a != 64 || psn_a != 1 || urn_a != 1 || ps_a !== 1'b1) begin
      errors++;
      $display("FAIL single_p1: hi=%0d ps=%0d ur=%0d last_ps=%b want 64 1 1 1",
               hi_a, psn_a, urn_a, ps_a);
    end
    clr();
    step(256);
    checks++;
    if (hi_a != 64 || urn_a != 1 || ur_a !== 1'b1) begin
      errors++;
      $display("FAIL single_p2: hi=%0d ur=%0d last_ur=%b want 64 1 1",
               hi_a, urn_a, ur_a);
    end
  endtask

  task automatic test_preload();
    clr();
    send_a(8'd200);
    checks++;
    if (ifa.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL preload_rdy: got %b want 0", ifa.sample_ready);
    end
    step(255);
    checks++;
    if (hi_a != 64 || psn_a != 1 || urn_a != 0 || ifa.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL preload_p: hi=%0d ps=%0d ur=%0d rdy=%b want 64 1 0 1",
               hi_a, psn_a, urn_a, ifa.sample_ready);
    end
    clr();
    step(256);
    checks++;
    if (hi_a != 200) begin
      errors++;
      $display("FAIL preload_hi: got %0d want 200", hi_a);
    end
  endtask

  task automatic test_bypass();
    clr();
    step(255);
    ifa.sample_in    = 8'd10;
    ifa.sample_valid = 1'b1;
    step(1);
    ifa.sample_valid = 1'b0;
    checks++;
    if (ps_a !== 1'b1 || urn_a != 0 || ifa.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_edge: ps=%b ur=%0d rdy=%b want 1 0 1",
               ps_a, urn_a, ifa.sample_ready);
    end
    clr();
    step(256);
    checks++;
    if (hi_a != 10) begin
      errors++;
      $display("FAIL bypass_hi: got %0d want 10", hi_a);
    end
  endtask

  task automatic test_extremes();
    clr();
    send_a(8'd0);
    step(255);
    checks++;
    if (hi_a != 10) begin
      errors++;
      $display("FAIL ext_pre: got %0d want 10", hi_a);
    end
    clr();
    send_a(8'd255);
    step(255);
    checks++;
    if (hi_a != 0) begin
      errors++;
      $display("FAIL duty0: got %0d want 0", hi_a);
    end
    clr();
    step(255);
    checks++;
    if (hi_a != 255 || pwm_a !== 1'b1) begin
      errors++;
      $display("FAIL duty255_hi: hi=%0d pwm=%b want 255 1", hi_a, pwm_a);
    end
    step(1);
    checks++;
    if (pwm_a !== 1'b0 || hi_a != 255) begin
      errors++;
      $display("FAIL duty255_low: pwm=%b hi=%0d want 0 255", pwm_a, hi_a);
    end
  endtask

  task automatic test_prescale();
    send_b(8'd128);
    checks++;
    if (ps_b !== 1'b1) begin
      errors++;
      $display("FAIL psc_first_ps: got %b want 1", ps_b);
    end
    clr();
    step(1023);
    checks++;
    if (hi_b != 512 || psn_b != 0) begin
      errors++;
      $display("FAIL psc_p1: hi=%0d ps=%0d want 512 0", hi_b, psn_b);
    end
    step(1);
    checks++;
    if (ps_b !== 1'b1 || ur_b !== 1'b1) begin
      errors++;
      $display("FAIL psc_edge: ps=%b ur=%b want 1 1", ps_b, ur_b);
    end
    clr();
    step(1024);
    checks++;
    if (hi_b != 512 || psn_b != 1 || ps_b !== 1'b1) begin
      errors++;
      $display("FAIL psc_p2: hi=%0d ps=%0d last=%b want 512 1 1",
               hi_b, psn_b, ps_b);
    end
  endtask

  task automatic test_reset_mid();
    send_a(8'd77);
    checks++;
    if (ifa.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold: rdy=%b want 0", ifa.sample_ready);
    end
    step(50);
    checks++;
    if (pwm_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_prerst: pwm=%b want 1", pwm_a);
    end
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if ({pwm_a, ps_a, ur_a, ifa.sample_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_rst: got %b want 0001",
               {pwm_a, ps_a, ur_a, ifa.sample_ready});
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    step(2);
    send_a(8'd32);
    checks++;
    if (ps_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart_ps: got %b want 1", ps_a);
    end
    clr();
    step(256);
    checks++;
    if (hi_a != 32) begin
      errors++;
      $display("FAIL mid_p1: got %0d want 32", hi_a);
    end
    clr();
    step(256);
    checks++;
    if (hi_a != 32 || urn_a != 1) begin
      errors++;
      $display("FAIL mid_p2: hi=%0d ur=%0d want 32 1", hi_a, urn_a);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    test_reset();
    test_single();
    test_preload();
    test_bypass();
    test_extremes();
    test_prescale();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
